// File: rtl/qmax_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// qmax_update_ctrl_if
//   Bundles the request/response handshakes of the Qmax update controller and
//   its connection to the Qmax table into one interface.
//
//   slave  : the controller side
//   master : the environment side (lookup/update clients plus the table)
//
//   Signals
//     i_clear / o_init_done                       re-run zero-fill / table ready
//     i_lkp_valid, i_lkp_state, o_lkp_ready,
//     o_lkp_valid, o_lkp_data                     action-selection lookups
//     i_upd_valid, i_upd_state, i_upd_q,
//     o_upd_ready, o_upd_written                  Qmax update requests
//     o_tbl_addr_r, o_tbl_read_en, o_tbl_addr_w,
//     o_tbl_write_en, o_tbl_wdata, i_tbl_rdata    table ports (1-cycle read)
// -----------------------------------------------------------------------------
interface qmax_update_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  i_clear;
    logic                  o_init_done;

    logic                  i_lkp_valid;
    logic [ADDR_WIDTH-1:0] i_lkp_state;
    logic                  o_lkp_ready;
    logic                  o_lkp_valid;
    logic [DATA_WIDTH-1:0] o_lkp_data;

    logic                  i_upd_valid;
    logic [ADDR_WIDTH-1:0] i_upd_state;
    logic [DATA_WIDTH-1:0] i_upd_q;
    logic                  o_upd_ready;
    logic                  o_upd_written;

    logic [ADDR_WIDTH-1:0] o_tbl_addr_r;
    logic                  o_tbl_read_en;
    logic [ADDR_WIDTH-1:0] o_tbl_addr_w;
    logic                  o_tbl_write_en;
    logic [DATA_WIDTH-1:0] o_tbl_wdata;
    logic [DATA_WIDTH-1:0] i_tbl_rdata;

    modport slave (
        input  i_clear,
        output o_init_done,
        input  i_lkp_valid, i_lkp_state,
        output o_lkp_ready, o_lkp_valid, o_lkp_data,
        input  i_upd_valid, i_upd_state, i_upd_q,
        output o_upd_ready, o_upd_written,
        output o_tbl_addr_r, o_tbl_read_en, o_tbl_addr_w, o_tbl_write_en, o_tbl_wdata,
        input  i_tbl_rdata
    );

    modport master (
        output i_clear,
        input  o_init_done,
        output i_lkp_valid, i_lkp_state,
        input  o_lkp_ready, o_lkp_valid, o_lkp_data,
        output i_upd_valid, i_upd_state, i_upd_q,
        input  o_upd_ready, o_upd_written,
        input  o_tbl_addr_r, o_tbl_read_en, o_tbl_addr_w, o_tbl_write_en, o_tbl_wdata,
        output i_tbl_rdata
    );
endinterface

// File: rtl/qmax_update_ctrl.sv
// -----------------------------------------------------------------------------
// qmax_update_ctrl
//   Sequencer and read-port arbiter for the Qmax table (1 read + 1 write port,
//   1-cycle read latency).
//     - Zero-fills the table after reset or on i_clear (the table itself has
//       no reset).
//     - Runs read-compare-conditional-write Qmax updates: the candidate is
//       written only when it is strictly greater than the stored value.
//     - Shares the read port with action-selection lookups; lookups win.
//
//   Ports
//     i_clk  clock
//     i_rst  asynchronous reset, active-high
//     bus    qmax_update_ctrl_if.slave (handshakes and table ports)
//
//   States
//     INIT  sweep writing zero to every entry, requests ignored
//     IDLE  arbitrate clear / lookup / update
//     RD    a lookup's data returns this cycle; arbitrates like IDLE but
//           does not take i_clear
//     CMP   update data returns; compare and conditionally write
// -----------------------------------------------------------------------------
module qmax_update_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int FLOAT      = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    qmax_update_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RD   = 2'd2,
        CMP  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] upd_state_q;
    logic [DATA_WIDTH-1:0] upd_q_q;
    logic                  lkp_valid_q;

    logic                  lkp_accept;
    logic                  upd_accept;
    logic                  upd_wins;

    // Strict greater-than. In float mode the operands are ordered as
    // sign/magnitude numbers, with +0 and -0 treated as equal.
    function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-2:0] mag_a;
        logic [DATA_WIDTH-2:0] mag_b;
        mag_a = a[DATA_WIDTH-2:0];
        mag_b = b[DATA_WIDTH-2:0];
        if (FLOAT != 0) begin
            if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
                return !a[DATA_WIDTH-1] && !((mag_a == '0) && (mag_b == '0));
            else if (!a[DATA_WIDTH-1])
                return mag_a > mag_b;
            else
                return mag_a < mag_b;
        end
        return a > b;
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        lkp_accept = 1'b0;
        upd_accept = 1'b0;
        upd_wins   = 1'b0;

        case (state)
            INIT: begin
                if (init_cnt == LAST_ADDR)
                    state_next = IDLE;
            end
            IDLE, RD: begin
                if ((state == IDLE) && bus.i_clear) begin
                    state_next = INIT;
                end else if (bus.i_lkp_valid) begin
                    lkp_accept = 1'b1;
                    state_next = RD;
                end else if (bus.i_upd_valid) begin
                    upd_accept = 1'b1;
                    state_next = CMP;
                end else begin
                    state_next = IDLE;
                end
            end
            CMP: begin
                upd_wins   = gt(upd_q_q, bus.i_tbl_rdata);
                state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    // Table and handshake outputs. The reset gate keeps the INIT sweep from
    // writing while i_rst is still held.
    always_comb begin
        bus.o_lkp_ready    = lkp_accept;
        bus.o_upd_ready    = upd_accept;
        bus.o_tbl_read_en  = lkp_accept || upd_accept;
        bus.o_tbl_addr_r   = lkp_accept ? bus.i_lkp_state : bus.i_upd_state;
        bus.o_tbl_write_en = !i_rst && ((state == INIT) || upd_wins);
        bus.o_tbl_addr_w   = (state == INIT) ? init_cnt : upd_state_q;
        bus.o_tbl_wdata    = (state == INIT) ? '0 : upd_q_q;
        bus.o_upd_written  = upd_wins;
    end

    assign bus.o_init_done = (state != INIT);
    assign bus.o_lkp_valid = lkp_valid_q;
    assign bus.o_lkp_data  = bus.i_tbl_rdata;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // NOTE: the latched update operands are reset along with the control
    // state; the table contents cannot be reset, which is why INIT exists.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= INIT;
            init_cnt    <= '0;
            upd_state_q <= '0;
            upd_q_q     <= '0;
            lkp_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            lkp_valid_q <= lkp_accept;

            if (state == INIT)
                init_cnt <= (init_cnt == LAST_ADDR) ? '0 : init_cnt + 1'b1;
            else if (state_next == INIT)
                init_cnt <= '0;

            if (upd_accept) begin
                upd_state_q <= bus.i_upd_state;
                upd_q_q     <= bus.i_upd_q;
            end
        end
    end

endmodule

// File: tb/tb_qmax_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qmax_update_ctrl
//   Self-checking bench for qmax_update_ctrl: a behavioural table model on the
//   table ports, a directed vector table, hand-written multi-cycle sequences
//   and a randomized phase checked against a value-level Qmax model.
// -----------------------------------------------------------------------------
module tb_qmax_update_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    always #5 i_clk = ~i_clk;

    qmax_update_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    qmax_update_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .FLOAT     (1)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    // Table model: 1 read + 1 write port, registered read data. "poison"
    // fills it with garbage so the zero-fill sweep has something to erase.
    logic [DW-1:0] mem [DEPTH];
    logic          poison = 1'b1;

    always @(posedge i_clk) begin
        if (poison) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEAD_BEEF;
        end else if (bus.o_tbl_write_en) begin
            mem[bus.o_tbl_addr_w] <= bus.o_tbl_wdata;
        end
        if (bus.o_tbl_read_en) bus.i_tbl_rdata <= mem[bus.o_tbl_addr_r];
    end

    // Reference model: the value each entry must hold.
    logic [DW-1:0] ref_mem [DEPTH];

    // IEEE-754 singles order like signed integers built from sign and
    // magnitude; +0 and -0 both map to 0.
    function automatic longint fkey(input logic [31:0] v);
        longint m;
        m = longint'(v[30:0]);
        return v[31] ? -m : m;
    endfunction

    function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b);
        return fkey(a) > fkey(b);
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Starts at a falling edge, takes two cycles, ends at a falling edge.
    // A lookup is offered during CMP to confirm it is refused there.
    task automatic do_update(input logic [AW-1:0] s, input logic [DW-1:0] q, input bit exp_w);
        bus.i_upd_valid = 1'b1;
        bus.i_upd_state = s;
        bus.i_upd_q     = q;
        #1;
        check("upd_ready", bus.o_upd_ready, 1);
        check("upd_read_en", bus.o_tbl_read_en, 1);
        check("upd_addr_r", bus.o_tbl_addr_r, s);
        @(negedge i_clk);
        bus.i_upd_valid = 1'b0;
        bus.i_lkp_valid = 1'b1;
        bus.i_lkp_state = s;
        #1;
        check("cmp_lkp_ready", bus.o_lkp_ready, 0);
        check("upd_written", bus.o_upd_written, exp_w);
        check("upd_write_en", bus.o_tbl_write_en, exp_w);
        if (exp_w) begin
            check("upd_addr_w", bus.o_tbl_addr_w, s);
            check("upd_wdata", bus.o_tbl_wdata, q);
        end
        @(negedge i_clk);
        bus.i_lkp_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [AW-1:0] s, input logic [DW-1:0] exp_d);
        bus.i_lkp_valid = 1'b1;
        bus.i_lkp_state = s;
        #1;
        check("lkp_ready", bus.o_lkp_ready, 1);
        check("lkp_addr_r", bus.o_tbl_addr_r, s);
        @(negedge i_clk);
        bus.i_lkp_valid = 1'b0;
        #1;
        check("lkp_valid", bus.o_lkp_valid, 1);
        check("lkp_data", bus.o_lkp_data, exp_d);
        @(negedge i_clk);
    endtask

    task automatic apply_update(input logic [AW-1:0] s, input logic [DW-1:0] q);
        bit w;
        w = ref_gt(q, ref_mem[s]);
        do_update(s, q, w);
        if (w) ref_mem[s] = q;
    endtask

    typedef struct {
        bit            is_upd;
        logic [AW-1:0] s;
        logic [DW-1:0] q;
        bit            exp_w;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [DW-1:0] q;

        vecs[0]  = '{1'b1, 6'd5, 32'h3F80_0000, 1'b1, 32'h0};          // 1.0 over 0
        vecs[1]  = '{1'b1, 6'd5, 32'h3F00_0000, 1'b0, 32'h0};          // 0.5 over 1.0
        vecs[2]  = '{1'b1, 6'd6, 32'hBF80_0000, 1'b0, 32'h0};          // -1.0 over 0
        vecs[3]  = '{1'b1, 6'd6, 32'h8000_0000, 1'b0, 32'h0};          // -0 over +0
        vecs[4]  = '{1'b0, 6'd5, 32'h0,         1'b0, 32'h3F80_0000};
        vecs[5]  = '{1'b0, 6'd6, 32'h0,         1'b0, 32'h0};
        vecs[6]  = '{1'b1, 6'd7, 32'h4000_0000, 1'b1, 32'h0};          // 2.0
        vecs[7]  = '{1'b1, 6'd7, 32'h4040_0000, 1'b1, 32'h0};          // 3.0 back-to-back
        vecs[8]  = '{1'b0, 6'd7, 32'h0,         1'b0, 32'h4040_0000};
        vecs[9]  = '{1'b1, 6'd8, 32'h0000_0001, 1'b1, 32'h0};          // smallest denormal
        vecs[10] = '{1'b1, 6'd8, 32'h8000_0005, 1'b0, 32'h0};          // negative under it
        vecs[11] = '{1'b1, 6'd8, 32'h0000_0001, 1'b0, 32'h0};          // equal, no write
        vecs[12] = '{1'b1, 6'd9, 32'hC000_0000, 1'b0, 32'h0};          // -2.0 over 0
        vecs[13] = '{1'b0, 6'd9, 32'h0,         1'b0, 32'h0};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // ---- reset: requests pending, everything must stay quiet ----
        bus.i_clear     = 1'b0;
        bus.i_lkp_valid = 1'b1;
        bus.i_lkp_state = '0;
        bus.i_upd_valid = 1'b1;
        bus.i_upd_state = '0;
        bus.i_upd_q     = 32'h3F80_0000;
        repeat (2) @(negedge i_clk);
        #1;
        check("rst_write_en", bus.o_tbl_write_en, 0);
        check("rst_read_en", bus.o_tbl_read_en, 0);
        check("rst_lkp_ready", bus.o_lkp_ready, 0);
        check("rst_upd_ready", bus.o_upd_ready, 0);
        check("rst_lkp_valid", bus.o_lkp_valid, 0);
        check("rst_upd_written", bus.o_upd_written, 0);
        check("rst_init_done", bus.o_init_done, 0);

        // ---- zero-fill sweep after release: 64 writes, addr 0..63 ----
        @(negedge i_clk);
        poison = 1'b0;
        i_rst  = 1'b0;
        #1;
        for (int c = 0; c < DEPTH; c++) begin
            check("init_write_en", bus.o_tbl_write_en, 1);
            check("init_addr_w", bus.o_tbl_addr_w, c);
            check("init_wdata", bus.o_tbl_wdata, 0);
            check("init_done_low", bus.o_init_done, 0);
            check("init_lkp_ready", bus.o_lkp_ready, 0);
            check("init_upd_ready", bus.o_upd_ready, 0);
            @(negedge i_clk);
            #1;
        end
        bus.i_lkp_valid = 1'b0;
        bus.i_upd_valid = 1'b0;
        check("init_done_cycle65", bus.o_init_done, 1);
        check("idle_write_en", bus.o_tbl_write_en, 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'h0) bad++;
        check("table_zeroed", bad, 0);
        @(negedge i_clk);

        // ---- directed vectors ----
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_upd) begin
                do_update(vecs[i].s, vecs[i].q, vecs[i].exp_w);
                if (vecs[i].exp_w) ref_mem[vecs[i].s] = vecs[i].q;
            end else begin
                do_lookup(vecs[i].s, vecs[i].exp_data);
            end
        end

        // ---- lookup and update together: lookup first, update next cycle ----
        bus.i_lkp_valid = 1'b1;
        bus.i_lkp_state = 6'd5;
        bus.i_upd_valid = 1'b1;
        bus.i_upd_state = 6'd10;
        bus.i_upd_q     = 32'h4000_0000;
        #1;
        check("both_lkp_ready", bus.o_lkp_ready, 1);
        check("both_upd_ready_wait", bus.o_upd_ready, 0);
        check("both_addr_r", bus.o_tbl_addr_r, 5);
        @(negedge i_clk);
        bus.i_lkp_valid = 1'b0;
        #1;
        check("both_lkp_valid", bus.o_lkp_valid, 1);
        check("both_lkp_data", bus.o_lkp_data, 32'h3F80_0000);
        check("both_upd_ready", bus.o_upd_ready, 1);
        check("both_upd_addr_r", bus.o_tbl_addr_r, 10);
        @(negedge i_clk);
        bus.i_upd_valid = 1'b0;
        #1;
        check("both_upd_written", bus.o_upd_written, 1);
        check("both_upd_addr_w", bus.o_tbl_addr_w, 10);
        ref_mem[10] = 32'h4000_0000;
        @(negedge i_clk);

        // ---- back-to-back lookups, one per cycle ----
        bus.i_lkp_valid = 1'b1;
        bus.i_lkp_state = 6'd5;
        #1;
        check("b2b_ready0", bus.o_lkp_ready, 1);
        @(negedge i_clk);
        bus.i_lkp_state = 6'd7;
        #1;
        check("b2b_ready1", bus.o_lkp_ready, 1);
        check("b2b_valid0", bus.o_lkp_valid, 1);
        check("b2b_data0", bus.o_lkp_data, 32'h3F80_0000);
        @(negedge i_clk);
        bus.i_lkp_valid = 1'b0;
        #1;
        check("b2b_valid1", bus.o_lkp_valid, 1);
        check("b2b_data1", bus.o_lkp_data, 32'h4040_0000);
        @(negedge i_clk);
        #1;
        check("b2b_valid_pulse", bus.o_lkp_valid, 0);
        @(negedge i_clk);

        // ---- randomized traffic against the reference model ----
        for (int it = 0; it < 300; it++) begin
            logic [AW-1:0] s;
            s = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                do_lookup(s, ref_mem[s]);
            end else begin
                case ($urandom_range(0, 3))
                    0:       q = $urandom;
                    1:       q = ref_mem[s];
                    2:       q = {~ref_mem[s][31], ref_mem[s][30:0]};
                    default: q = {1'($urandom_range(0, 1)), 8'd127, 23'($urandom_range(0, 15))};
                endcase
                if (q[30:23] == 8'hFF) q[30] = 1'b0;
                apply_update(s, q);
            end
        end

        // ---- i_clear re-sweep, interrupted by reset at cnt=20 ----
        bus.i_clear = 1'b1;
        #1;
        check("clr_idle_write_en", bus.o_tbl_write_en, 0);
        @(negedge i_clk);
        bus.i_clear = 1'b0;
        #1;
        check("clr_init_done", bus.o_init_done, 0);
        check("clr_write_en", bus.o_tbl_write_en, 1);
        check("clr_addr_w0", bus.o_tbl_addr_w, 0);
        repeat (20) @(negedge i_clk);
        #1;
        check("clr_addr_w20", bus.o_tbl_addr_w, 20);
        i_rst = 1'b1;
        #1;
        check("midrst_write_en", bus.o_tbl_write_en, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("midrst_restart_addr", bus.o_tbl_addr_w, 0);
        check("midrst_restart_we", bus.o_tbl_write_en, 1);
        n = 0;
        while (!bus.o_init_done && n < 200) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        check("resweep_cycles", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(negedge i_clk);
        do_lookup(6'd5, ref_mem[5]);
        do_lookup(6'd7, ref_mem[7]);
        apply_update(6'd5, 32'h3F00_0000);
        do_lookup(6'd5, ref_mem[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
